// File: rtl/mem_ctrl_pkg.sv
// Shared widths, default depth and FSM encodings for the single-port memory controller.
package mem_ctrl_pkg;
  localparam int MEMADDRSIZE  = 5;
  localparam int DATASIZE     = 8;
  localparam int MEMDEPTH_DEF = 25;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
endpackage

// File: rtl/mem_ctrl.sv
// Request/response front end for a combinational-read data memory: one access
// per request, out-of-range addresses answered with an error and counted.
//
// state  | meaning
// IDLE   | ready for a request; memory address follows req_addr
// ACCESS | registered request drives the memory for one cycle
// RESP   | response held until the consumer takes it
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEMDEPTH = MEMDEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [MEMADDRSIZE-1:0] req_addr,
  input  logic [DATASIZE-1:0]    req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATASIZE-1:0]    rsp_rdata,
  output logic                   rsp_err,
  output logic                   mem_wr,
  output logic [MEMADDRSIZE-1:0] mem_addr,
  output logic [DATASIZE-1:0]    mem_datain,
  input  logic [DATASIZE-1:0]    mem_dataout,
  output logic [7:0]             err_cnt
);

  // One extra bit so a depth equal to the full address space still compares correctly.
  localparam logic [MEMADDRSIZE:0] DEPTH_L = (MEMADDRSIZE+1)'(MEMDEPTH);

  logic [1:0]             state, state_nxt;
  logic                   wr_q;
  logic [MEMADDRSIZE-1:0] addr_q;
  logic [DATASIZE-1:0]    wdata_q;
  logic                   accept;
  logic                   out_of_range;

  assign accept       = req_valid && (state == ST_IDLE);
  assign out_of_range = ({1'b0, req_addr} >= DEPTH_L);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = out_of_range ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output decode straight from the state register so reset removes mem_wr without a clock.
  always_comb begin
    req_ready  = (state == ST_IDLE);
    rsp_valid  = (state == ST_RESP);
    mem_wr     = (state == ST_ACCESS) && wr_q;
    mem_addr   = (state == ST_IDLE) ? req_addr : addr_q;
    mem_datain = wdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wr_q    <= req_wr;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rsp_err <= out_of_range;
        if (out_of_range) begin
          rsp_rdata <= '0;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end
      if (state == ST_ACCESS) rsp_rdata <= wr_q ? '0 : mem_dataout;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a 32-word behavioural memory attached.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [4:0] req_addr = 5'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_datain;
  logic [7:0] mem_dataout;
  logic [7:0] err_cnt;

  mem_ctrl #(.MEMDEPTH(25)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_dataout(mem_dataout),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] mem   [32];
  logic [7:0] model [32];
  int wr_pulses = 0;
  int last_wr_addr = -1;
  int cyc_cnt = 0;
  int last_acc = 0;
  int acc_gap = 0;
  int checks = 0;
  int failures = 0;

  assign mem_dataout = mem[mem_addr];

  always @(posedge clk) begin
    cyc_cnt = cyc_cnt + 1;
    if (mem_wr) begin
      mem[mem_addr] = mem_datain;
      wr_pulses = wr_pulses + 1;
      last_wr_addr = int'(mem_addr);
    end
    if (req_valid && req_ready) begin
      acc_gap = cyc_cnt - last_acc;
      last_acc = cyc_cnt;
    end
  end

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request; hold > 0 keeps rsp_ready low for that many RESP cycles.
  task automatic txn(input logic wr, input logic [4:0] a, input logic [7:0] wd, input int hold);
    exp_t e;
    int lat, cyc, p0;
    logic [7:0] held;
    e.err   = (a >= 5'd25);
    e.rdata = (wr || e.err) ? 8'd0 : model[a];
    e.lat   = e.err ? 1 : 2;
    sb.push_back(e);
    if (wr && !e.err) model[a] = wd;
    p0 = wr_pulses;
    @(negedge clk);
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    if (cyc >= 20) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_wr    = 1'($urandom_range(0, 1));
    req_addr  = 5'($urandom_range(0, 31));
    req_wdata = 8'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    e = sb.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("rsp_err", 32'(rsp_err), 32'(e.err));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
    if (hold > 0) begin
      held = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
        chk("stall_valid", 32'(rsp_valid), 32'd1);
        chk("stall_rdata", 32'(rsp_rdata), 32'(held));
        chk("stall_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("idle_after_ready", 32'(req_ready), 32'd1);
    end
    chk("wr_pulses", 32'(wr_pulses - p0), (wr && !e.err) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i]   = 8'(i * 7 + 17);
      model[i] = 8'(i * 7 + 17);
    end
    req_addr = 5'd9;
    #23;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("idle_mem_addr", 32'(mem_addr), 32'd9);
    @(negedge clk);
    rst = 1'b1;

    txn(1'b1, 5'd3, 8'hA5, 0);
    chk("store_wr_addr", 32'(last_wr_addr), 32'd3);
    txn(1'b0, 5'd3, 8'h00, 0);
    txn(1'b0, 5'd10, 8'h00, 5);

    // Reset in the ACCESS cycle of a store must suppress the write.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 5'd7; req_wdata = 8'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    chk("access_mem_wr", 32'(mem_wr), 32'd1);
    #2 rst = 1'b0;
    #1 chk("rst_async_mem_wr", 32'(mem_wr), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    chk("post_rst_mem7", 32'(mem[7]), 32'(model[7]));

    txn(1'b0, 5'd25, 8'h00, 0);
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
    txn(1'b1, 5'd30, 8'h77, 0);
    chk("oor_store_mem", 32'(mem[30]), 32'(model[30]));

    for (int i = 0; i < 25; i++) begin
      txn(1'b0, 5'(i), 8'h00, 0);
      if (i > 0) chk("acc_gap", 32'(acc_gap), 32'd3);
    end

    for (int i = 0; i < 300; i++) txn(1'(i % 2), 5'($urandom_range(25, 31)), 8'(i), 0);
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    txn(1'b0, 5'd3, 8'h00, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
